alu_resp_checker: RTL and testbench
===================================

// Module: alu_resp_checker
// PURPOSE
//  Response-side counterpart to the ALU stimulus driver: samples a/b/op and the ALU's out/c.
//  Checks them against an internal reference model delayed by the DUT latency.
//  Keeps saturating transaction/error counts and captures the first failing vector.
//  Raises pass/done when the stimulus side signals end of test.
//  Sits in the verification environment beside alu_if; synthesizable for FPGA bring-up.
// PARAMETERS
//  WIDTH  4   operand/result width (a, b, out)
//  LAT    0   DUT latency in cycles from a/b/op to out/c (0..7)
//  CNT_W  16  width of txn_cnt/err_cnt
// PORTS
//  clk              in   1       single clock, all logic on posedge
//  rst              in   1       synchronous, active-high reset
//  start            in   1       pulse: clear counters/capture, enter RUN
//  smp_valid        in   1       a/b/op valid this cycle (one txn per valid cycle)
//  a                in   WIDTH   operand A as driven to DUT
//  b                in   WIDTH   operand B as driven to DUT
//  op               in   2       opcode as driven to DUT
//  out              in   WIDTH   DUT result
//  c                in   1       DUT carry/borrow flag
//  test_finished    in   1       stimulus side done (level)
//  busy             out  1       high in RUN and DRAIN
//  done             out  1       high in DONE
//  pass             out  1       done && err_cnt==0 && txn_cnt!=0
//  mismatch         out  1       1-cycle pulse on each failing compare
//  txn_cnt          out  CNT_W   compared transactions, saturating
//  err_cnt          out  CNT_W   mismatches, saturating
//  fe_valid         out  1       first-error capture valid (sticky)
//  fe_vec           out  3*WIDTH+3  {a,b,op,out,c} of first failure
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, delay line valid bits cleared.
//  Model: op 00 {c,out}=a+b; 01 {c,out}=a-b (c=borrow, a<b); 10 out=a&b, c=0; 11 out=a|b, c=0.
//  Expected {c,out} and a valid bit enter a LAT-deep shift register on each smp_valid in RUN.
//    LAT=0 compares same cycle.
//  Compare: when the delayed valid bit is 1, compare out/c sampled that cycle against the
//    delayed expectation. txn_cnt+1. On mismatch: err_cnt+1 and pulse mismatch.
//    If !fe_valid, also load fe_vec from the delayed a/b/op with the live out/c.
//  Counters saturate at 2^CNT_W-1; no wrap.
//  mismatch is registered: it asserts the cycle after the compare.
//  FSM:
//    IDLE  -(start)->                     RUN
//    RUN   -(test_finished)->             DRAIN  (smp_valid ignored from this cycle)
//    DRAIN -(delay line empty, or LAT=0)-> DONE  (pending compares complete)
//    DONE  -(start)->                     RUN    (counters/capture cleared)
//  start in RUN/DRAIN: restart; clears counters, capture and delay line.
//  start with test_finished in the same cycle: start wins, enter RUN.
//  smp_valid outside RUN: no sample, no count.
//  rst mid-test: immediate return to IDLE; in-flight compares discarded.
// CONFIGURATION
//  ALU_CHK_OPCOV_EN defined: adds out port op_hits (4*CNT_W), per-opcode saturating counts
//    of compared txns. done additionally requires every op count >=1 for pass.
//  Not defined: port and counters absent; pass as above.
// TESTING
//  LAT=0, start, 4 txns (3+4,op00->7,c0;2-5,op01->D,c1;C&A->8;C|3->F) correct -> txn 4, err 0, pass=1
//  LAT=2, correct DUT, 100 random txns then test_finished -> DRAIN 2 cycles, done, txn 100, pass
//  Inject out=6 for 3+4 op00 as 3rd txn -> mismatch pulse once, err 1, fe_vec={3,4,00,6,0}, pass 0
//  CNT_W=4, 20 mismatching txns -> err_cnt holds 15, fe_vec = first failure
//  rst asserted during RUN with 2 txns in flight (LAT=2) -> IDLE, counters 0, no later compares
//  ALU_CHK_OPCOV_EN, only ops 00/01 driven, all correct -> done=1, pass=0, op_hits[2]=op_hits[3]=0

Source files
------------

// File: rtl/alu_resp_checker.sv
// rtl/alu_resp_checker.sv - ALU response checker: delayed reference model, saturating scoreboard, first-error capture
// Optional feature macro: ALU_CHK_OPCOV_EN adds per-opcode coverage counters (op_hits) that also gate pass.
module alu_resp_checker #(
  parameter int WIDTH = 4,
  parameter int LAT   = 0,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 smp_valid,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           op,
  input  logic [WIDTH-1:0]     out,
  input  logic                 c,
  input  logic                 test_finished,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 mismatch,
  output logic [CNT_W-1:0]     txn_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic                 fe_valid,
  output logic [3*WIDTH+2:0]   fe_vec
`ifdef ALU_CHK_OPCOV_EN
  ,
  output logic [4*CNT_W-1:0]   op_hits
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int DW = 3*WIDTH+3;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   exp_res;
  logic             accept;
  logic             d_valid;
  logic             line_empty;
  logic             cmp_en;
  logic             cmp_bad;
  logic             cov_ok;
  logic [WIDTH:0]   d_exp;
  logic [WIDTH-1:0] d_a;
  logic [WIDTH-1:0] d_b;
  logic [1:0]       d_op;
  logic [CNT_W-1:0] txn_q;
  logic [CNT_W-1:0] err_q;
  logic             mismatch_q;
  logic             fe_valid_q;
  logic [DW-1:0]    fe_q;

  // The carry-out bit of the widened subtraction is exactly the borrow (a < b).
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    exp_res = sum;
    case (op)
      2'b00:   exp_res = sum;
      2'b01:   exp_res = diff;
      2'b10:   exp_res = {1'b0, a & b};
      default: exp_res = {1'b0, a | b};
    endcase
  end

  assign accept = (state == S_RUN) && smp_valid && !test_finished && !start;

  generate
    if (LAT == 0) begin : g_direct
      assign d_valid    = accept;
      assign d_exp      = exp_res;
      assign d_a        = a;
      assign d_b        = b;
      assign d_op       = op;
      assign line_empty = 1'b1;
    end else begin : g_pipe
      logic [LAT-1:0]         v_q;
      logic [LAT-1:0][DW-1:0] e_q;

      always_ff @(posedge clk) begin
        if (rst || start) begin
          v_q <= '0;
        end else begin
          v_q <= (v_q << 1) | LAT'(accept);
        end
      end

      // Payload needs no reset: it is only ever consumed under its valid bit.
      always_ff @(posedge clk) begin
        e_q <= (e_q << DW) | (LAT*DW)'({exp_res, a, b, op});
      end

      assign d_valid                 = v_q[LAT-1];
      assign {d_exp, d_a, d_b, d_op} = e_q[LAT-1];
      assign line_empty              = (v_q == '0);
    end
  endgenerate

  assign cmp_en  = d_valid && !start;
  assign cmp_bad = ({c, out} != d_exp);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      txn_q      <= '0;
      err_q      <= '0;
      mismatch_q <= 1'b0;
      fe_valid_q <= 1'b0;
      fe_q       <= '0;
    end else if (start) begin
      state      <= S_RUN;
      txn_q      <= '0;
      err_q      <= '0;
      mismatch_q <= 1'b0;
      fe_valid_q <= 1'b0;
      fe_q       <= '0;
    end else begin
      mismatch_q <= cmp_en && cmp_bad;
      if (cmp_en) begin
        if (txn_q != CNT_MAX) txn_q <= txn_q + CNT_ONE;
        if (cmp_bad) begin
          if (err_q != CNT_MAX) err_q <= err_q + CNT_ONE;
          if (!fe_valid_q) begin
            fe_valid_q <= 1'b1;
            fe_q       <= {d_a, d_b, d_op, out, c};
          end
        end
      end
      case (state)
        S_RUN:   if (test_finished) state <= S_DRAIN;
        S_DRAIN: if (line_empty) state <= S_DONE;
        default: state <= state;
      endcase
    end
  end

`ifdef ALU_CHK_OPCOV_EN
  logic [CNT_W-1:0] hits_q [4];

  always_ff @(posedge clk) begin
    if (rst || start) begin
      hits_q[0] <= '0;
      hits_q[1] <= '0;
      hits_q[2] <= '0;
      hits_q[3] <= '0;
    end else if (cmp_en && (hits_q[d_op] != CNT_MAX)) begin
      hits_q[d_op] <= hits_q[d_op] + CNT_ONE;
    end
  end

  assign op_hits = {hits_q[3], hits_q[2], hits_q[1], hits_q[0]};
  assign cov_ok  = (hits_q[0] != '0) && (hits_q[1] != '0) &&
                   (hits_q[2] != '0) && (hits_q[3] != '0);
`else
  assign cov_ok = 1'b1;
`endif

  assign busy     = (state == S_RUN) || (state == S_DRAIN);
  assign done     = (state == S_DONE);
  assign pass     = done && (err_q == '0) && (txn_q != '0) && cov_ok;
  assign mismatch = mismatch_q;
  assign txn_cnt  = txn_q;
  assign err_cnt  = err_q;
  assign fe_valid = fe_valid_q;
  assign fe_vec   = fe_q;

endmodule

// File: tb/tb_alu_resp_checker.sv
// tb/tb_alu_resp_checker.sv - bench for alu_resp_checker: LAT=0/CNT_W=4 and LAT=2/CNT_W=16 instances side by side
module tb_alu_resp_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       smp_valid = 1'b0;
  logic       test_finished = 1'b0;
  logic [3:0] a = 4'd0;
  logic [3:0] b = 4'd0;
  logic [1:0] op = 2'd0;
  logic       cur_bad = 1'b0;

  logic [3:0]  out0, out2;
  logic        c0, c2;
  logic        busy0, done0, pass0, mm0, fev0;
  logic        busy2, done2, pass2, mm2, fev2;
  logic [3:0]  txn0, err0;
  logic [15:0] txn2, err2;
  logic [14:0] fe0, fe2;
`ifdef ALU_CHK_OPCOV_EN
  logic [15:0] hits0;
  logic [63:0] hits2;
`endif

  logic [10:0] h0 = '0;
  logic [10:0] h1 = '0;

  int         nchk = 0;
  int         nerr = 0;
  int         n_txn = 0;
  int         n_err = 0;
  int         n_op [4];
  logic       fe_have = 1'b0;
  logic [14:0] fe_exp = '0;
  int         mmc0 = 0;
  int         mmc2 = 0;
  int         m0, m2;

  always #5 clk = ~clk;

  function automatic logic [4:0] ref_alu(input logic [3:0] x, input logic [3:0] y, input logic [1:0] o);
    int   r;
    logic cf;
    case (o)
      2'd0:    begin r = int'(x) + int'(y); cf = (r > 15); end
      2'd1:    begin r = int'(x) - int'(y); cf = (r < 0);  end
      2'd2:    begin r = int'(x & y);       cf = 1'b0;     end
      default: begin r = int'(x | y);       cf = 1'b0;     end
    endcase
    return {cf, 4'(r & 15)};
  endfunction

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Behavioural ALUs: zero-latency for u0, two-cycle pipeline for u2; a bad txn flips out[0].
  always_comb {c0, out0} = ref_alu(a, b, op) ^ {4'b0000, cur_bad};
  always_comb {c2, out2} = ref_alu(h1[3:0], h1[7:4], h1[9:8]) ^ {4'b0000, h1[10]};

  always @(posedge clk) begin
    h0 <= {cur_bad, op, b, a};
    h1 <= h0;
  end

  always @(negedge clk) begin
    if (mm0 === 1'b1) mmc0++;
    if (mm2 === 1'b1) mmc2++;
  end

  alu_resp_checker #(.WIDTH(4), .LAT(0), .CNT_W(4)) u0 (
    .clk(clk), .rst(rst), .start(start), .smp_valid(smp_valid),
    .a(a), .b(b), .op(op), .out(out0), .c(c0), .test_finished(test_finished),
    .busy(busy0), .done(done0), .pass(pass0), .mismatch(mm0),
    .txn_cnt(txn0), .err_cnt(err0), .fe_valid(fev0), .fe_vec(fe0)
`ifdef ALU_CHK_OPCOV_EN
    , .op_hits(hits0)
`endif
  );

  alu_resp_checker #(.WIDTH(4), .LAT(2), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .start(start), .smp_valid(smp_valid),
    .a(a), .b(b), .op(op), .out(out2), .c(c2), .test_finished(test_finished),
    .busy(busy2), .done(done2), .pass(pass2), .mismatch(mm2),
    .txn_cnt(txn2), .err_cnt(err2), .fe_valid(fev2), .fe_vec(fe2)
`ifdef ALU_CHK_OPCOV_EN
    , .op_hits(hits2)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_sb();
    n_txn   = 0;
    n_err   = 0;
    fe_have = 1'b0;
    fe_exp  = '0;
    for (int k = 0; k < 4; k++) n_op[k] = 0;
  endtask

  task automatic drive(input logic [3:0] ta, input logic [3:0] tb, input logic [1:0] top, input logic tbad);
    logic [4:0] r;
    a = ta; b = tb; op = top; cur_bad = tbad; smp_valid = 1'b1;
    r = ref_alu(ta, tb, top) ^ {4'b0000, tbad};
    n_txn++;
    n_op[top]++;
    if (tbad) begin
      n_err++;
      if (!fe_have) begin
        fe_have = 1'b1;
        fe_exp  = {ta, tb, top, r[3:0], r[4]};
      end
    end
    @(posedge clk); #1;
    smp_valid = 1'b0;
    cur_bad   = 1'b0;
  endtask

  task automatic do_start(input logic with_tf);
    start = 1'b1;
    test_finished = with_tf;
    @(posedge clk); #1;
    start = 1'b0;
    test_finished = 1'b0;
    clear_sb();
  endtask

  task automatic finish_test(input string tag, input int exp_cyc);
    int cyc;
    int cyc2;
    cyc = 0;
    cyc2 = 0;
    test_finished = 1'b1;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (done2 && cyc2 == 0) cyc2 = cyc;
    end while (!(done0 && done2) && cyc < 20);
    chk({tag, "_done"}, {62'd0, done0, done2}, 64'd3);
    if (exp_cyc > 0) chk({tag, "_drain_cycles"}, cyc2, exp_cyc);
    test_finished = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic exp_pass;
    exp_pass = (n_err == 0) && (n_txn != 0);
`ifdef ALU_CHK_OPCOV_EN
    for (int k = 0; k < 4; k++) begin
      if (n_op[k] == 0) exp_pass = 1'b0;
      chk({tag, "_hits0"}, hits0[k*4 +: 4], sat15(n_op[k]));
      chk({tag, "_hits2"}, hits2[k*16 +: 16], n_op[k]);
    end
`endif
    chk({tag, "_txn0"}, txn0, sat15(n_txn));
    chk({tag, "_err0"}, err0, sat15(n_err));
    chk({tag, "_txn2"}, txn2, n_txn);
    chk({tag, "_err2"}, err2, n_err);
    chk({tag, "_fev0"}, fev0, fe_have);
    chk({tag, "_fev2"}, fev2, fe_have);
    if (fe_have) begin
      chk({tag, "_fe0"}, fe0, fe_exp);
      chk({tag, "_fe2"}, fe2, fe_exp);
    end
    chk({tag, "_pass0"}, pass0, exp_pass);
    chk({tag, "_pass2"}, pass2, exp_pass);
  endtask

  initial begin
    clear_sb();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {busy0, busy2}, 0);
    chk("rst_done", {done0, done2}, 0);
    chk("rst_pass", {pass0, pass2}, 0);
    chk("rst_mismatch", {mm0, mm2}, 0);
    chk("rst_txn0", txn0, 0);
    chk("rst_err0", err0, 0);
    chk("rst_txn2", txn2, 0);
    chk("rst_err2", err2, 0);
    chk("rst_fev", {fev0, fev2}, 0);
    chk("rst_fe0", fe0, 0);
    chk("rst_fe2", fe2, 0);
    rst = 1'b0;

    // samples in IDLE are ignored
    a = 4'd3; b = 4'd4; op = 2'd0; smp_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    smp_valid = 1'b0;
    chk("idle_txn0", txn0, 0);
    chk("idle_txn2", txn2, 0);
    chk("idle_busy", {busy0, busy2}, 0);

    // directed, all four opcodes correct
    do_start(1'b0);
    chk("run_busy", {busy0, busy2}, 2'b11);
    drive(4'h3, 4'h4, 2'd0, 1'b0);
    drive(4'h2, 4'h5, 2'd1, 1'b0);
    drive(4'hC, 4'hA, 2'd2, 1'b0);
    drive(4'hC, 4'h3, 2'd3, 1'b0);
    finish_test("dir", 3);
    check_all("dir");
    chk("dir_fe_none", {fev0, fev2}, 0);

    // 100 random correct txns with random gaps
    do_start(1'b0);
    while (n_txn < 100) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end else begin
        drive(4'($urandom), 4'($urandom), 2'($urandom), 1'b0);
      end
    end
    finish_test("rnd", 3);
    check_all("rnd");

    // samples in DONE are ignored
    smp_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    smp_valid = 1'b0;
    chk("done_ignore_txn2", txn2, n_txn);
    chk("done_still", {done0, done2}, 2'b11);

    // start beats test_finished; one injected error on the 3rd txn
    do_start(1'b1);
    chk("start_wins_busy", {busy0, busy2}, 2'b11);
    chk("start_wins_done", {done0, done2}, 0);
    m0 = mmc0;
    m2 = mmc2;
    drive(4'h1, 4'h2, 2'd0, 1'b0);
    drive(4'h9, 4'h9, 2'd3, 1'b0);
    drive(4'h3, 4'h4, 2'd0, 1'b1);
    drive(4'h5, 4'h1, 2'd1, 1'b0);
    drive(4'h7, 4'h8, 2'd2, 1'b0);
    finish_test("inj", 3);
    check_all("inj");
    chk("inj_fe_value", fe2, {4'd3, 4'd4, 2'd0, 4'd6, 1'b0});
    chk("inj_pulses0", mmc0 - m0, 1);
    chk("inj_pulses2", mmc2 - m2, 1);

    // 20 failing txns: u0 error count saturates at 15
    do_start(1'b0);
    m0 = mmc0;
    m2 = mmc2;
    repeat (20) drive(4'($urandom), 4'($urandom), 2'($urandom), 1'b1);
    finish_test("sat", 3);
    check_all("sat");
    chk("sat_err0_hold", err0, 15);
    chk("sat_pulses0", mmc0 - m0, 20);
    chk("sat_pulses2", mmc2 - m2, 20);

    // reset with two failing txns still in u2's delay line
    do_start(1'b0);
    m2 = mmc2;
    drive(4'($urandom), 4'($urandom), 2'($urandom), 1'b1);
    drive(4'($urandom), 4'($urandom), 2'($urandom), 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_sb();
    chk("midrst_txn2", txn2, 0);
    chk("midrst_err0", err0, 0);
    chk("midrst_busy", {busy0, busy2}, 0);
    smp_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    smp_valid = 1'b0;
    chk("midrst_later_txn2", txn2, 0);
    chk("midrst_later_err2", err2, 0);
    chk("midrst_pulses2", mmc2 - m2, 0);
    chk("midrst_fev2", fev2, 0);

    // only add/sub exercised, all correct
    do_start(1'b0);
    repeat (10) drive(4'($urandom), 4'($urandom), 2'($urandom_range(0, 1)), 1'b0);
    finish_test("cov", 3);
    check_all("cov");
`ifdef ALU_CHK_OPCOV_EN
    chk("cov_pass_blocked", pass2, 0);
    chk("cov_hits2_op2", hits2[47:32], 0);
    chk("cov_hits2_op3", hits2[63:48], 0);
`else
    chk("cov_pass", pass2, 1);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
